// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects bytes little-endian into 32-bit words; word_valid pulses the cycle
// after the fourth byte of a word is accepted.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] sr;

  assign last_lane = (lane == 2'(WORD_BYTES - 1));

  // Earlier bytes shift down so the first byte ends up in word[7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
      end else if (byte_valid) begin
        if (last_lane) begin
          word       <= {byte_data, sr};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          sr   <= {byte_data, sr[23:8]};
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses LEN/data/CSUM byte frames and writes words into
// instruction memory while holding the CPU via busy.
// Handshake: a byte moves only on a cycle where rx_valid && rx_ready; rx_ready
// depends on state alone, never on rx_valid.
module imem_loader
  import imem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            wr_en,
  output logic [XLEN-1:0] wr_addr,
  output logic [31:0]     wr_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [15:0]     words_loaded
);

  localparam int LEN_W = 8 * LEN_BYTES;

  state_t           state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [7:0]       csum;
  logic             xfer;
  logic             start_ok;
  logic             last_lane;
  logic             word_valid;
  logic [31:0]      word;
  logic [LEN_W-1:0] len_full;

  assign rx_ready = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign busy     = rx_ready;
  assign xfer     = rx_valid && rx_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_full = {rx_data, len_lo};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (xfer && (state == S_DATA)),
    .byte_data  (rx_data),
    .last_lane  (last_lane),
    .word_valid (word_valid),
    .word       (word)
  );

  assign wr_en   = word_valid;
  assign wr_data = word;
  // words_loaded advances in the write cycle, so this is the pre-increment index.
  assign wr_addr = BASE_ADDR + (XLEN'(words_loaded) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len          <= '0;
      csum         <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (word_valid) words_loaded <= words_loaded + 16'd1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok) begin
            state        <= S_LEN0;
            done         <= 1'b0;
            err          <= 1'b0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len_lo <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            len  <= len_full;
            csum <= csum ^ rx_data;
            if (32'(len_full) > 32'(DEPTH)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (len_full == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ rx_data;
            // The previous word's write has always retired by a word's last byte.
            if (last_lane && (({1'b0, words_loaded} + 17'd1) == 17'(len))) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] data_q[$];
  bit          gaps;
  int          start_at;
  int          byte_idx;

  imem_loader #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("wr_unexpected", {31'b0, wr_en}, 32'd0);
      end else begin
        check("wr_addr", wr_addr, exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic check_reset_values();
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_words", {16'b0, words_loaded}, 32'd0);
  endtask

  // driver: called #1 after a rising edge; returns #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int t;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    if (start_at == byte_idx) start = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rdy_timeout", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
    byte_idx++;
  endtask

  task automatic start_pulse(input logic [7:0] junk);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = junk;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  // reference model: a frame of len words either loads fully or is rejected
  task automatic run_frame(input int len, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] l16;
    bit          fits;
    int          t;
    l16  = 16'(len);
    fits = (len <= DEPTH);
    cs   = 8'h00;
    byte_idx = 0;
    start_pulse(l16[7:0]);
    send_byte(l16[7:0]);
    cs ^= l16[7:0];
    send_byte(l16[15:8]);
    cs ^= l16[15:8];
    if (!fits) begin
      @(negedge clk);
      check("ovf_rx_ready", {31'b0, rx_ready}, 32'd0);
      check("ovf_err", {31'b0, err}, 32'd1);
      check("ovf_done", {31'b0, done}, 32'd0);
      check("ovf_busy", {31'b0, busy}, 32'd0);
      check("ovf_words", {16'b0, words_loaded}, 32'd0);
      @(posedge clk);
      #1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_data_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs);
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("frame_busy", {31'b0, busy}, 32'd0);
    check("frame_done", {31'b0, done}, {31'b0, !bad_csum});
    check("frame_err", {31'b0, err}, {31'b0, bad_csum});
    check("frame_words", {16'b0, words_loaded}, 32'(len));
    check("frame_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("frame_writes_left", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    gaps     = 1'b0;
    start_at = -1;
    byte_idx = 0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two-word directed frame
    data_q = {32'h44332211, 32'h88776655};
    run_frame(2, 1'b0);
    check("wr_data_last", wr_data, 32'h88776655);

    // empty frames, good then bad checksum
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);

    // single word with a wrong checksum still writes
    run_frame(1, 1'b1);

    // length overflow
    run_frame(DEPTH + 1, 1'b0);

    // gapped rx_valid with a start pulse landing mid-frame
    gaps     = 1'b1;
    start_at = 6;
    run_frame(3, 1'b0);
    gaps     = 1'b0;
    start_at = -1;

    // reset mid-frame after two data bytes
    byte_idx = 0;
    start_pulse(8'h02);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid_wr_en", {31'b0, wr_en}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(2, 1'b0);

    // random frames
    repeat (8) begin
      gaps = ($urandom_range(0, 1) == 1);
      run_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
    end
    gaps = 1'b0;

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
